// File: rtl/gshare_bp.sv
// gshare_bp: per-slot 2-bit saturating-counter direction predictor for one
// aligned fetch group, optionally indexed by PC XOR speculative global history.
// Lookups have one cycle of latency. Training is a single-cycle
// read-modify-write. A lookup that hits the entry being trained in the same
// cycle sees the trained value.
module gshare_bp #(
   parameter int FETCH_WIDTH = 4,
   parameter int IDX_W       = 9,
   parameter int HIST_LEN    = 8,
   parameter int USE_GHR     = 1,
   localparam int OFF_W      = $clog2(FETCH_WIDTH * 4),
   localparam int SLOT_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   input  logic [63:0]            req_pc,
   output logic                   resp_valid,
   output logic [FETCH_WIDTH-1:0] resp_taken,
   output logic [HIST_LEN-1:0]    resp_ghr,
   input  logic                   spec_valid,
   input  logic                   spec_taken,
   input  logic                   recover_valid,
   input  logic [HIST_LEN-1:0]    recover_ghr,
   input  logic                   upd_valid,
   input  logic [63:0]            upd_pc,
   input  logic [SLOT_W-1:0]      upd_slot,
   input  logic [HIST_LEN-1:0]    upd_ghr,
   input  logic                   upd_taken
);

   localparam int DEPTH = 1 << IDX_W;

   logic [HIST_LEN-1:0]    ghr_reg;
   logic [HIST_LEN-1:0]    ghr_next;
   logic [HIST_LEN-1:0]    ghr_shift;
   logic [IDX_W-1:0]       lk_idx;
   logic [IDX_W-1:0]       upd_idx;
   logic [FETCH_WIDTH-1:0] lk_taken;
   logic                   resp_valid_reg;
   logic [FETCH_WIDTH-1:0] resp_taken_reg;
   logic [HIST_LEN-1:0]    resp_ghr_reg;

   // PC bits outside the group index, and the slot select of a single-slot
   // build, carry no information for this predictor.
   logic unused_bits;
   assign unused_bits = ^{req_pc[63:OFF_W+IDX_W], req_pc[OFF_W-1:0],
                          upd_pc[63:OFF_W+IDX_W], upd_pc[OFF_W-1:0],
                          upd_ghr, upd_slot};

   // History is zero-extended into the index. In bimodal mode it is still
   // tracked and returned, but it is not used for indexing.
   assign lk_idx  = (USE_GHR != 0) ? (req_pc[OFF_W+IDX_W-1:OFF_W] ^ IDX_W'(ghr_reg))
                                   : req_pc[OFF_W+IDX_W-1:OFF_W];
   assign upd_idx = (USE_GHR != 0) ? (upd_pc[OFF_W+IDX_W-1:OFF_W] ^ IDX_W'(upd_ghr))
                                   : upd_pc[OFF_W+IDX_W-1:OFF_W];

   // The newest outcome enters at the LSB. A one-bit history simply becomes
   // the new outcome.
   generate
      if (HIST_LEN == 1) begin : g_ghr_one
         assign ghr_shift = spec_taken;
      end else begin : g_ghr_multi
         assign ghr_shift = {ghr_reg[HIST_LEN-2:0], spec_taken};
      end
   endgenerate

   // Select the next history. Recovery wins over a speculative push.
   always_comb begin
      ghr_next = ghr_reg;
      if (recover_valid) begin
         ghr_next = recover_ghr;
      end else if (spec_valid) begin
         ghr_next = ghr_shift;
      end
   end

   // History register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ghr_reg <= '0;
      end else begin
         ghr_reg <= ghr_next;
      end
   end

   // One counter bank per slot. Training only touches the bank that
   // upd_slot selects.
   generate
      for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_bank
         logic [1:0] cnt_mem [DEPTH];
         logic [1:0] upd_old;
         logic [1:0] upd_new;
         logic [1:0] lk_cnt;
         logic       upd_hit;

         assign upd_hit = upd_valid && ((FETCH_WIDTH == 1) || (upd_slot == SLOT_W'(gi)));
         assign upd_old = cnt_mem[upd_idx];

         // Saturating step toward the resolved direction. The counter
         // never wraps.
         always_comb begin
            upd_new = upd_old;
            if (upd_taken) begin
               if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
            end else begin
               if (upd_old != 2'b00) upd_new = upd_old - 2'd1;
            end
         end

         // Write-first bypass: a lookup of the entry being trained sees
         // the trained value.
         assign lk_cnt       = (upd_hit && (upd_idx == lk_idx)) ? upd_new : cnt_mem[lk_idx];
         assign lk_taken[gi] = lk_cnt[1];

         // Counter storage. Each counter resets to weakly not-taken.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int j = 0; j < DEPTH; j++) cnt_mem[j] <= 2'b01;
            end else if (upd_hit) begin
               cnt_mem[upd_idx] <= upd_new;
            end
         end
      end
   endgenerate

   // Register the response. Data holds between requests; the valid bit
   // pulses for one cycle per request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_valid_reg <= 1'b0;
         resp_taken_reg <= '0;
         resp_ghr_reg   <= '0;
      end else begin
         resp_valid_reg <= req_valid;
         if (req_valid) begin
            resp_taken_reg <= lk_taken;
            resp_ghr_reg   <= ghr_reg;
         end
      end
   end

   assign resp_valid = resp_valid_reg;
   assign resp_taken = resp_taken_reg;
   assign resp_ghr   = resp_ghr_reg;

endmodule

// File: doc/gshare_bp.md
Name: gshare_bp

Overview:
- Parametrised successor to the fetch-stage 2-bit predictor.
- Provides FETCH_WIDTH parallel 2-bit saturating-counter predictions per aligned fetch group.
- Indexing is optionally hashed with a speculative global history register (gshare mode).
- Sits in fetch beside the I-cache request; trained from the commit/branch-resolve path; history recovered on mispredict.

Parameters:
- FETCH_WIDTH, 4, slots per fetch group; power of two, 1..8; one PHT bank per slot.
- IDX_W, 9, PHT index width; DEPTH = 2^IDX_W entries per bank.
- HIST_LEN, 8, global history bits; 0 < HIST_LEN <= IDX_W.
- USE_GHR, 1, 1 = gshare index, 0 = bimodal (history ignored for indexing, still maintained).
- OFF_W, log2(FETCH_WIDTH*4), PC bits below the group index (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  lookup request.
- req_pc  in  64  fetch-group PC; low OFF_W bits ignored.
- resp_valid  out  1  prediction valid, exactly one cycle after the accepted request.
- resp_taken  out  FETCH_WIDTH  per-slot prediction = counter[1].
- resp_ghr  out  HIST_LEN  GHR value used to index this prediction.
- spec_valid  in  1  push a speculative outcome into the GHR.
- spec_taken  in  1  outcome bit pushed.
- recover_valid  in  1  overwrite the GHR (mispredict).
- recover_ghr  in  HIST_LEN  restored history, already including the corrected outcome.
- upd_valid  in  1  train one counter.
- upd_pc  in  64  PC of the resolved group.
- upd_slot  in  log2(FETCH_WIDTH)  slot within the group; width 1 when FETCH_WIDTH = 1.
- upd_ghr  in  HIST_LEN  history snapshot returned with the prediction.
- upd_taken  in  1  resolved direction.

Behaviour:
- Index: gidx(pc,h) = pc[OFF_W+IDX_W-1:OFF_W] XOR zero-extended h when USE_GHR = 1; otherwise pc[OFF_W+IDX_W-1:OFF_W].
- Lookup index: gidx(req_pc, GHR).
- Update index: gidx(upd_pc, upd_ghr), applied to bank upd_slot.
- Storage is flops, not RAM. Every counter resets to 2'b01 (weakly not-taken).
- Lookup latency is 1. When req_valid is high in cycle T, the block registers:
  - resp_taken[i] = bit 1 of bank i at the lookup index;
  - resp_ghr = GHR value in cycle T.
  - resp_valid = 1 in T+1 only.
  - resp_taken and resp_ghr hold their values while resp_valid = 0.
- Update is a read-modify-write in one cycle:
  - taken: counter = min(counter+1, 3).
  - not taken: counter = max(counter-1, 0).
  - Saturates; never wraps.
- Same-cycle lookup and update of the same bank and index is write-first: the response reflects the post-update counter. Other banks and indices are unaffected.
- GHR update each cycle, in priority order:
  - recover_valid: GHR = recover_ghr; a simultaneous spec_valid is dropped.
  - else spec_valid: GHR = {GHR[HIST_LEN-2:0], spec_taken}, newest bit at LSB. For HIST_LEN = 1, GHR = spec_taken.
  - else: hold.
- A lookup in the same cycle as a GHR change uses the old GHR. The new value is visible from the next cycle.
- Reset values: GHR = 0, resp_valid = 0, resp_taken = 0, resp_ghr = 0.
- Reset asserted mid-operation clears everything immediately and asynchronously, including a pending response. An in-flight update in that cycle is lost.
- No back-pressure. A request every cycle is legal, giving back-to-back responses.

Test Plan:
- Reset, default params; req_pc = 0x8000_0000 -> next cycle resp_valid = 1, resp_taken = 4'b0000, resp_ghr = 0. Cycle after, with no request -> resp_valid = 0.
- Saturation: upd_pc = 0x1000, slot 2, upd_ghr = 0, upd_taken = 1, applied 3 times -> lookup 0x1000 gives resp_taken = 4'b0100. Then 1 not-taken -> still 4'b0100. Then 1 more not-taken -> 4'b0000. Then 5 more not-taken -> counter stays 0, no wrap.
- Gshare aliasing: push spec_taken = 1 three times -> GHR = 8'h07, and lookup resp_ghr = 8'h07. Train slot 0 at pc 0x1000 with upd_ghr = 0x07, upd_taken = 1, twice -> lookup pc 0x1000 gives slot 0 taken. Set USE_GHR = 0 -> the same lookup hits a different entry, so slot 0 is not taken.
- Collision: same-cycle req_pc = upd_pc = 0x2000, slot 1, counter at 1, upd_taken = 1 -> response bit 1 = 1 (write-first).
- Recover priority: GHR = 0x0F; same cycle spec_valid = 1 with spec_taken = 1, and recover_valid = 1 with recover_ghr = 0x30 -> GHR = 0x30 next cycle. A lookup in that cycle returns resp_ghr = 0x0F.
- Async reset: drop reset mid-stream with a pending response -> resp_valid = 0 immediately without a clock edge. After release, all counters are 01 and GHR = 0.
